// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell reused WIDTH times, LSB first.
// Latency: accept edge t0, RUN on edges t0+1..t0+WIDTH, result valid after t0+WIDTH.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module serial_adder_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid,
  input  logic             out_ready
);

  // Bit counter needs at least one bit so WIDTH=1 still has a terminal compare.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             c_out_q;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_next;

  // The single full-adder cell, fed from the LSBs of the operand shifters.
  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Sum shifter enters new bits at the MSB; a one-bit shifter is just the new bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next = sum_bit;
    end else begin : g_wn
      assign s_next = {sum_bit, s_sh[WIDTH-1:1]};
    end
  endgenerate

  // Handshake flags come straight from the state register, no input feed-through.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

  // Sequencer: load operands in IDLE, one bit per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_sh  <= s_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q   <= s_next;
            c_out_q <= carry_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Testbench for serial_adder_seq: WIDTH=4 directed and random operations plus WIDTH=1 exhaustive.
// Expected results come from plain integer addition of the operands.
// Covers reset, latency, backpressure, mid-RUN reset and back-to-back throughput.
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic       c_in = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, c_out, out_valid;
  logic [3:0] sum;

  logic       a1 = 1'b0, b1 = 1'b0, c_in1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic       in_ready1, c_out1, out_valid1;
  logic [0:0] sum1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  serial_adder_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .c_out(c_out), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  serial_adder_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(c_in1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sum(sum1), .c_out(c_out1), .out_valid(out_valid1),
    .out_ready(out_ready1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: the full sum a + b + c_in as an integer.
  function automatic int ref_add(input int av, input int bv, input int cv);
    return av + bv + cv;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 operation from IDLE; stall = cycles out_ready is held low in DONE.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                       input int stall, input string tag);
    int lat;
    int e;
    e = ref_add(int'(av), int'(bv), int'(cv));
    chk({tag, "_in_ready"}, in_ready, 1);
    a = av; b = bv; c_in = cv; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_sum"}, sum, e & 15);
    chk({tag, "_cout"}, c_out, (e >> 4) & 1);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] hs_sum;
    logic       hs_c;
    int         q[$];
    int         last_acc;
    int         accepted;
    int         got;
    int         e;
    logic       hs;
    logic       ohs;
    int         lat;

    // Reset held for two cycles.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);

    // Directed operations.
    do_op(4'h5, 4'h3, 1'b1, 0, "op_5_3_1");
    do_op(4'hF, 4'h1, 1'b0, 0, "op_F_1_0");
    do_op(4'hF, 4'hF, 1'b1, 0, "op_F_F_1");

    // Backpressure: hold DONE for 5 cycles while offering new operands.
    e = ref_add(9, 12, 1);
    a = 4'h9; b = 4'hC; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom);
      in_valid = (i % 2 == 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, e & 15);
      chk("bp_cout", c_out, (e >> 4) & 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_idle", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_no_second_accept", {in_ready, out_valid}, 2'b10);
    end

    // Reset during the second RUN cycle discards the operation.
    a = 4'h7; b = 4'h6; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_idle", {in_ready, out_valid}, 2'b10);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", c_out, 0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("midrst_no_valid", lat, 0);
    do_op(4'h2, 4'h2, 1'b0, 0, "op_after_rst");

    // Random operations with random consumer stalls.
    for (int n = 0; n < 10; n++) begin
      do_op(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand_op");
    end

    // Back-to-back: in_valid and out_ready held high.
    a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; accepted = 0; got = 0;
    for (int k = 0; k < 80 && got < 6; k++) begin
      hs     = in_valid && in_ready;
      ohs    = out_valid && out_ready;
      hs_sum = sum;
      hs_c   = c_out;
      if (hs) q.push_back(ref_add(int'(a), int'(b), int'(c_in)));
      tick();
      if (ohs) begin
        chk("b2b_queue_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_sum", hs_sum, e & 15);
          chk("b2b_cout", hs_c, (e >> 4) & 1);
        end
        got++;
      end
      if (hs) begin
        if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 6);
        last_acc = cyc;
        accepted++;
        if (accepted == 6) in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom);
      end
    end
    chk("b2b_results", got, 6);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();

    // WIDTH=1 exhaustive: one RUN cycle, {c_out,sum} = a+b+c_in.
    chk("w1_rst_idle", {in_ready1, out_valid1}, 2'b10);
    for (int v = 0; v < 8; v++) begin
      e = ref_add(v & 1, (v >> 1) & 1, (v >> 2) & 1);
      a1 = 1'(v); b1 = 1'(v >> 1); c_in1 = 1'(v >> 2);
      in_valid1 = 1'b1; out_ready1 = 1'b0;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 10) begin
        tick();
        lat++;
      end
      chk("w1_latency", lat, 1);
      chk("w1_sum", sum1, e & 1);
      chk("w1_cout", c_out1, (e >> 1) & 1);
      out_ready1 = 1'b1;
      tick();
      chk("w1_back_idle", {in_ready1, out_valid1}, 2'b10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
